// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types for the reorder buffer and its neighbours.
package cpu_pkg;
    localparam int ROB_DEPTH = 16;
    localparam int ROBID_W   = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 4;
    localparam int NUM_CPL   = 2;
    typedef logic [ROBID_W-1:0] robid_t;
    typedef logic [PREG_W-1:0]  preg_t;
    typedef struct packed {
        logic  valid;
        logic  done;
        logic  has_dest;
        preg_t oldpreg;
    } rob_entry_t;
endpackage

// File: rtl/rob_retire_ctrl_if.sv
// rob_retire_ctrl_if: allocate, completion, flush and retire signals of the ROB.
interface rob_retire_ctrl_if;
    import cpu_pkg::*;
    logic                      alloc_valid;
    logic                      alloc_ready;
    logic                      alloc_has_dest;
    preg_t                     alloc_oldpreg;
    robid_t                    alloc_robid;
    logic [NUM_CPL-1:0]        cpl_valid;
    robid_t [NUM_CPL-1:0]      cpl_robid;
    logic                      flush;
    logic [PREG_W:0]           retire_out;
    robid_t                    retire_robid;
    logic                      retire_fire;
    logic [ROBID_W:0]          count;
    logic                      empty;
    logic                      full;
    modport master (
        output alloc_valid, alloc_has_dest, alloc_oldpreg, cpl_valid, cpl_robid, flush,
        input  alloc_ready, alloc_robid, retire_out, retire_robid, retire_fire, count, empty, full
    );
    modport slave (
        input  alloc_valid, alloc_has_dest, alloc_oldpreg, cpl_valid, cpl_robid, flush,
        output alloc_ready, alloc_robid, retire_out, retire_robid, retire_fire, count, empty, full
    );
endinterface

// File: rtl/rob_retire_ctrl.sv
// rob_retire_ctrl: in-order allocate, out-of-order complete, in-order retire reorder buffer.
module rob_retire_ctrl
    import cpu_pkg::*;
(
    input logic               clk,
    input logic               rst,
    rob_retire_ctrl_if.slave  rob
);
    typedef logic [ROBID_W:0] ptr_t;
    rob_entry_t [ROB_DEPTH-1:0] ent_q, ent_d;
    ptr_t            head_q, head_d, tail_q, tail_d;
    logic            retire_fire_q, retire_fire_d;
    robid_t          retire_robid_q, retire_robid_d;
    logic [PREG_W:0] retire_out_q, retire_out_d;
    robid_t          head_idx, tail_idx;
    logic            full, do_alloc, do_retire;
    assign head_idx  = head_q[ROBID_W-1:0];
    assign tail_idx  = tail_q[ROBID_W-1:0];
    assign full      = (head_idx == tail_idx) && (head_q[ROBID_W] != tail_q[ROBID_W]);
    assign do_alloc  = rob.alloc_valid && !full;
    assign do_retire = ent_q[head_idx].valid && ent_q[head_idx].done;
    assign rob.alloc_ready  = !full;
    assign rob.alloc_robid  = tail_idx;
    assign rob.full         = full;
    assign rob.empty        = head_q == tail_q;
    assign rob.count        = tail_q - head_q;
    assign rob.retire_fire  = retire_fire_q;
    assign rob.retire_robid = retire_robid_q;
    assign rob.retire_out   = retire_out_q;
    // Completions land before the retire clear so a late strobe cannot leave a stray done bit behind.
    always_comb begin
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        retire_fire_d  = 1'b0;
        retire_robid_d = '0;
        retire_out_d   = '0;
        if (rob.flush) begin
            ent_d  = '0;
            head_d = '0;
            tail_d = '0;
        end else begin
            for (int c = 0; c < NUM_CPL; c++)
                if (rob.cpl_valid[c] && ent_q[rob.cpl_robid[c]].valid)
                    ent_d[rob.cpl_robid[c]].done = 1'b1;
            if (do_retire) begin
                retire_fire_d   = 1'b1;
                retire_robid_d  = head_idx;
                retire_out_d    = {ent_q[head_idx].has_dest, ent_q[head_idx].oldpreg};
                ent_d[head_idx] = '0;
                head_d          = head_q + 1'b1;
            end
            if (do_alloc) begin
                ent_d[tail_idx] = '{valid: 1'b1, done: 1'b0, has_dest: rob.alloc_has_dest,
                                    oldpreg: rob.alloc_oldpreg};
                tail_d          = tail_q + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            ent_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            retire_fire_q  <= 1'b0;
            retire_robid_q <= '0;
            retire_out_q   <= '0;
        end else begin
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            retire_fire_q  <= retire_fire_d;
            retire_robid_q <= retire_robid_d;
            retire_out_q   <= retire_out_d;
        end
    end
endmodule

// File: doc/rob_retire_ctrl.md
# rob_retire_ctrl

Reorder-buffer controller between rename/issue and retirement in the out-of-order core. Allocates a ROB tag to each renamed instruction in program order, records functional-unit completions by tag, and retires completed instructions strictly in order. It returns each retired instruction's previous physical register to the renamer's `retirein` port.

## Interface
- `DEPTH`, 16: ROB entries; must be a power of two. Tag width `ROBID_W` = log2(DEPTH) = 4.
- `PREG_W`, 4: physical register tag width; matches the renamer `writeout`/`oldwrite` width.
- `NUM_CPL`, 2: number of completion (writeback) ports.
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-low reset.
- `alloc_valid`  in  1: renamed instruction is presented for allocation.
- `alloc_ready`  out  1: a free entry exists; equals `!full`.
- `alloc_has_dest`  in  1: the instruction writes a register.
- `alloc_oldpreg`  in  PREG_W: previous mapping of the destination (renamer `oldwrite`).
- `alloc_robid`  out  ROBID_W: tag assigned to the current allocation; equals the tail index.
- `cpl_valid`  in  NUM_CPL: per-port completion strobe.
- `cpl_robid`  in  NUM_CPL×ROBID_W: tag of the completed instruction per port.
- `flush`  in  1: discard all in-flight entries.
- `retire_out`  out  PREG_W+1: bit[PREG_W] is "free valid", bits[PREG_W-1:0] are the old physical register to free. Connects to renamer `retirein`.
- `retire_robid`  out  ROBID_W: tag of the entry retired this cycle.
- `retire_fire`  out  1: an entry retired this cycle, with or without a destination.
- `count`  out  ROBID_W+1: occupied entries, 0..DEPTH.
- `empty`, `full`  out  1 each.

## Operation
- Circular buffer with `head` and `tail` pointers of ROBID_W+1 bits; the MSB is a wrap bit.
  - `empty` = pointers equal.
  - `full` = indices equal and wrap bits differ.
  - `count` = tail − head, computed modulo 2^(ROBID_W+1).
- Each entry holds `valid`, `done`, `has_dest` and `oldpreg`.
- **Allocate:** when `alloc_valid && alloc_ready`, write the entry at the tail index with valid=1, done=0, and the presented fields; advance the tail.
  - `alloc_robid` is combinational from the tail.
- **Complete:** for each port with `cpl_valid` set, set `done` on the entry at `cpl_robid` if that entry is valid.
  - Completion to an invalid entry is ignored.
  - Repeated completion of the same entry is idempotent.
  - Both ports naming the same tag in one cycle is legal.
- **Retire:** at most one entry per cycle. When the head entry has valid && done at the clock edge:
  - clear the entry and advance the head;
  - register `retire_fire`=1, `retire_robid`=head index, and `retire_out`={has_dest, oldpreg}.
  - Otherwise all three outputs register to 0.
- **Flush:** highest priority.
  - Clears all valid/done bits and sets head=tail=0.
  - Suppresses allocate, complete and retire in that cycle.
  - Retire outputs register to 0.
  - No physical registers are returned; renamer recovery is handled elsewhere.
- **Priority per cycle:** reset > flush > (allocate, complete, retire applied concurrently).

## Timing
- **Reset** (`rst`=0 at the edge): head=tail=0, all entries invalid, `retire_out`=0, `retire_fire`=0, `retire_robid`=0. After reset, `count`=0, `empty`=1, `full`=0, `alloc_ready`=1.
- **Allocate-to-visible:** an entry allocated at edge E is valid after E. It can complete at edge E+1 at the earliest and retire at edge E+2 at the earliest.
- **Complete-to-retire:** a completion sampled at edge E (entry at head) produces retire at edge E+1. `retire_out` is valid for the one cycle following E+1.
- **Throughput:** back-to-back retire, one per cycle, when consecutive head entries are done.
- **Full:** `alloc_ready` derives from registered pointers only. A retire in the same cycle does not open a slot until the next cycle.
- **Allocate and retire in the same cycle:** both take effect; `count` is unchanged.
- **Wrap-around:** index rolls from DEPTH−1 to 0 and the wrap bit toggles. No special casing is needed.
- **Reset or flush mid-operation:** any partially complete state is discarded. No retire is emitted for discarded entries.

## Structure
- Shared package `cpu_pkg` holds:
  - `ROB_DEPTH`, `ROBID_W`, `PREG_W`;
  - the `rob_entry_t` struct (valid, done, has_dest, oldpreg);
  - the `robid_t` and `preg_t` typedefs.
- Single module; no sub-module. The entry array is a flop array indexed by pointer; it does not use RAM.

## Test plan
- **Reset, then fill:** assert `rst`=0 for 2 cycles, then allocate 16 instructions back-to-back.
  - `alloc_robid` is 0..15; `full`=1 and `count`=16 after the 16th; a 17th `alloc_valid` is refused.
- **Out-of-order completion:** allocate tags 0,1,2 with oldpreg 5,6,7; complete 2, then 1, then 0 on successive cycles.
  - No retire until tag 0 completes. Then `retire_out` = 5'h15, 5'h16, 5'h17 on three consecutive cycles.
- **No-destination entry:** allocate with `has_dest`=0 and oldpreg=9, then complete it.
  - `retire_fire`=1 and `retire_out`=5'h09 (bit4=0).
- **Wrap-around:** run 40 allocate/complete/retire cycles at a steady occupancy of 3.
  - Tags repeat modulo 16, `count` stays 3, and all 40 retires appear in allocation order.
- **Dual-port edge cases:** both ports complete the same tag; one port targets an unallocated tag.
  - A single retire occurs for the real tag; the stray completion has no effect.
- **Flush mid-stream:** with 5 entries, 2 of them done at head, assert `flush` for one cycle.
  - No retire occurs, `count`=0 next cycle, and the next allocation gets `alloc_robid`=0.
